window_3x3_gen: RTL and testbench
=================================

// Module: window_3x3_gen
// PURPOSE
//  Downstream of the video timing generator. Takes its registered {vsync,hsync,de} bus plus a pixel stream.
//  Builds a 3x3 neighbourhood from two internal line buffers for the noise-reduction filter core.
//  Re-emits the sync bus delayed to match the window.
// PARAMETERS
//  DW     8     pixel data width (bits)
//  MAX_W  2048  max active pixels per line; line-buffer depth
// PORTS
//  clk        in   1      pixel clock; all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  synci      in   3      {vsync,hsync,de}; bit2 vsync, bit1 hsync, bit0 de; active-high
//  pix_i      in   DW     pixel; sampled only when synci[0]=1
//  synco      out  3      synci delayed by exactly 2 cycles
//  win        out  9*DW   window, row-major: win[(3*r+c)*DW +: DW]; r0 = two lines up, c0 = two pixels earlier
//  win_valid  out  1      win holds a complete 3x3 neighbourhood
//  err_width  out  1      line-width mismatch flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: synco, win, win_valid and err_width = 0; x, y and ref_w = 0. Line-RAM contents undefined.
//  - Stage 1 registers synci/pix_i. Edge detection uses stage-1 de and vsync against their previous values.
//  - x (12 b): increments per de pixel; cleared to 0 on the de falling edge.
//  - y (11 b): increments on each de falling edge, saturating at 2047.
//  - y is cleared to 0 on the vsync rising edge. If that edge coincides with a de falling edge, vsync wins: y = 0.
//  - Line buffers lb0 and lb1, depth MAX_W, addressed by x, read-first.
//  - Per de pixel, both are read at x. Then lb0[x] <= pix and lb1[x] <= old lb0[x].
//  - Column shift: on a de pixel, each row shifts left one column. New right column = {old lb1[x], old lb0[x], pix}.
//  - No shift while de = 0; the window holds its last value.
//  - Latency: pixel and sync sampled at cycle t appear on win[2][2] and synco at t+2.
//  - win_valid = delayed de & (y >= 2) & (x >= 2), using that pixel's own x and y.
//  - x >= MAX_W: RAM write suppressed; rows 0 and 1 of the new column forced to 0; win_valid = 0.
//  - The x counter saturates at 4095.
//  - Reset mid-line or mid-frame: counters restart at 0. win_valid stays low until two full lines complete after reset.
//  - This holds even with no vsync, so stale RAM is never flagged valid.
//  - hsync is only delayed. Line boundaries are taken from de alone.
// CONFIGURATION
//  - LINE_WIDTH_CHK_EN defined:
//    - On the de falling edge with y == 0, ref_w <= x (pixels in the first line of the frame).
//    - On any later de falling edge with x != ref_w, err_width is set, 1 cycle after the edge.
//    - err_width is sticky and cleared on the vsync rising edge. If set and clear coincide, clear wins.
//  - LINE_WIDTH_CHK_EN undefined: ref_w logic is not built and err_width is tied to 0.
// TESTING
//  1. Reset held 3 cycles, then released with synci = 0. Required: all outputs 0 and win_valid never asserts.
//  2. Ramp frame, 8x4 active, pix = 16*y + x, 2-cycle blanking per line:
//     - first win_valid on row 2, col 2, with win = {00,01,02,10,11,12,20,21,22};
//     - exactly 12 valid cycles in the frame.
//  3. Arbitrary synci pattern. Required: synco equals synci delayed exactly 2 cycles, bit-for-bit, including hsync.
//  4. vsync rise and de fall on the same cycle. Required: y = 0 and win_valid stays low for the next two lines.
//  5. Frame with an 8-pixel line 0 and a 7-pixel line 2, LINE_WIDTH_CHK_EN defined:
//     - err_width rises 1 cycle after line 2's de falls and holds until the next vsync rise;
//     - with the macro undefined, err_width stays 0.
//  6. rst pulsed mid-line 3, then 4 lines streamed. Required: win_valid is first asserted on the third line after reset.

Source files
------------

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: 3x3 pixel neighbourhood generator for the noise-reduction core.
// Two line buffers plus three column shift rows build the window; the
// {vsync,hsync,de} bus is re-emitted with the same 2-cycle latency.
// Optional feature: define LINE_WIDTH_CHK_EN to build the line-width
// checker (ref_w / err_width); otherwise err_width is tied low.

// One window row: three columns, shifted left on each accepted pixel.
module window_3x3_row #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            shift,
    input  logic [DW-1:0]   din,
    output logic [3*DW-1:0] row   // c0 in low bits, c2 (newest) in high bits
);
    // Shift c1->c0, c2->c1, din->c2; hold while no pixel is accepted
    always_ff @(posedge clk) begin
        if (rst)
            row <= '0;
        else if (shift)
            row <= {din, row[2*DW +: DW], row[DW +: DW]};
    end
endmodule

module window_3x3_gen #(
    parameter int DW    = 8,
    parameter int MAX_W = 2048
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      synci,
    input  logic [DW-1:0]   pix_i,
    output logic [2:0]      synco,
    output logic [9*DW-1:0] win,
    output logic            win_valid,
    output logic            err_width
);
    localparam int STAGES = 2;
    localparam int XW     = 12;
    localparam int YW     = 11;
    localparam int AW     = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    localparam logic [XW-1:0] X_SAT = '1;
    localparam logic [YW-1:0] Y_SAT = '1;
    localparam logic [XW-1:0] X_TWO = XW'(2);
    localparam logic [YW-1:0] Y_TWO = YW'(2);
    localparam logic [XW:0]   W_LIM = (XW+1)'(MAX_W);

    typedef struct packed {
        logic vs;
        logic hs;
        logic de;
    } sync_t;

    sync_t [STAGES:1]     sync_pipe;
    logic [DW-1:0]        pix_q;
    logic                 de_q, vs_q;
    logic                 s1_live;   // stage 1 holds a real sample, not reset fill
    logic                 line_ok;   // blanking seen since reset; a line starts cleanly

    logic                 de_act, de_fall, vs_rise, x_in;
    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic [AW-1:0]        addr;
    logic [DW-1:0]        rd0, rd1;
    logic [2:0][DW-1:0]   col_new;
    logic [2:0][3*DW-1:0] rows;

    logic [DW-1:0] lb0 [MAX_W];   // previous line
    logic [DW-1:0] lb1 [MAX_W];   // two lines up

    // A partial line in flight at reset release is ignored entirely, so
    // y only advances on lines that were seen from their first pixel.
    assign de_act  = sync_pipe[1].de & line_ok;
    assign de_fall = de_q & ~sync_pipe[1].de & line_ok;
    assign vs_rise = sync_pipe[1].vs & ~vs_q;
    assign x_in    = {1'b0, x} < W_LIM;
    assign addr    = x[AW-1:0];
    assign synco   = sync_pipe[STAGES];

    // Sync delay line, stage-1 pixel register and edge-detect history
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_pipe <= '0;
            pix_q     <= '0;
            de_q      <= 1'b0;
            vs_q      <= 1'b0;
            s1_live   <= 1'b0;
            line_ok   <= 1'b0;
        end else begin
            sync_pipe[1] <= sync_t'(synci);
            for (int i = 2; i <= STAGES; i++)
                sync_pipe[i] <= sync_pipe[i-1];
            pix_q   <= pix_i;
            de_q    <= sync_pipe[1].de;
            vs_q    <= sync_pipe[1].vs;
            s1_live <= 1'b1;
            if (s1_live && !sync_pipe[1].de)
                line_ok <= 1'b1;
        end
    end

    // Column (x) and line (y) counters, both saturating; vsync beats de fall on y
    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else begin
            if (de_fall)
                x <= '0;
            else if (de_act && x != X_SAT)
                x <= x + XW'(1);

            if (vs_rise)
                y <= '0;
            else if (de_fall && y != Y_SAT)
                y <= y + YW'(1);
        end
    end

    // Line buffers, read-first: lb1 inherits what lb0 held at this column
    always_ff @(posedge clk) begin
        if (de_act && x_in) begin
            lb0[addr] <= pix_q;
            lb1[addr] <= lb0[addr];
        end
    end

    assign rd0 = lb0[addr];
    assign rd1 = lb1[addr];

    // New right-hand column; beyond the buffer depth the upper rows read as 0
    always_comb begin
        col_new    = '0;
        col_new[2] = pix_q;
        if (x_in) begin
            col_new[0] = rd1;
            col_new[1] = rd0;
        end
    end

    for (genvar r = 0; r < 3; r++) begin : g_row
        window_3x3_row #(.DW(DW)) u_row (
            .clk  (clk),
            .rst  (rst),
            .shift(de_act),
            .din  (col_new[r]),
            .row  (rows[r])
        );
    end

    assign win = rows;

    // Window is complete once two lines and two columns precede this pixel
    always_ff @(posedge clk) begin
        if (rst)
            win_valid <= 1'b0;
        else
            win_valid <= de_act & x_in & (x >= X_TWO) & (y >= Y_TWO);
    end

`ifdef LINE_WIDTH_CHK_EN
    logic [XW-1:0] ref_w;

    // First line of the frame sets the reference width; later lines must match
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_w     <= '0;
            err_width <= 1'b0;
        end else begin
            if (de_fall && y == '0)
                ref_w <= x;
            if (vs_rise)
                err_width <= 1'b0;
            else if (de_fall && y != '0 && x != ref_w)
                err_width <= 1'b1;
        end
    end
`else
    assign err_width = 1'b0;
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Randomised and directed bench for window_3x3_gen. The reference model
// tracks, per column, the last two pixels written there, and the window as
// a 3x3 grid of known/unknown cells; outputs are compared every cycle.
module tb_window_3x3_gen;
    localparam int DW    = 8;
    localparam int MAX_W = 16;
`ifdef LINE_WIDTH_CHK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      synci;
    logic [DW-1:0]   pix_i;
    logic [2:0]      synco;
    logic [9*DW-1:0] win;
    logic            win_valid;
    logic            err_width;

    window_3x3_gen #(.DW(DW), .MAX_W(MAX_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .synci    (synci),
        .pix_i    (pix_i),
        .synco    (synco),
        .win      (win),
        .win_valid(win_valid),
        .err_width(err_width)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int         m_x, m_y, m_ref;
    bit         m_prev_de, m_prev_vs, m_line_ok, m_err;
    int         ew [9];          // expected window cell, -1 = unknown RAM content
    int         hist [MAX_W][$]; // pixels written at each column, newest first
    logic [2:0] e_sync;
    bit         e_valid;

    // Observation helpers for directed tests
    int              vcnt;
    bit              got_first;
    logic [9*DW-1:0] first_win;

    task automatic model_reset();
        m_x = 0; m_y = 0; m_ref = 0; m_err = 0;
        m_prev_de = 0; m_prev_vs = 0; m_line_ok = 0;
        e_sync = '0; e_valid = 0;
        for (int i = 0; i < 9; i++) ew[i] = 0;
    endtask

    task automatic model_update(input logic [2:0] s, input logic [DW-1:0] p);
        bit de, vs, fall, rise;
        int c0, c1;
        de   = s[0];
        vs   = s[2];
        fall = m_line_ok && m_prev_de && !de;
        rise = vs && !m_prev_vs;
        e_sync  = s;
        e_valid = 0;
        if (de && m_line_ok) begin
            if (m_x < MAX_W) begin
                c1 = (hist[m_x].size() > 0) ? hist[m_x][0] : -1;
                c0 = (hist[m_x].size() > 1) ? hist[m_x][1] : -1;
                hist[m_x].push_front(int'(p));
                if (hist[m_x].size() > 2) void'(hist[m_x].pop_back());
                e_valid = (m_x >= 2) && (m_y >= 2);
            end else begin
                c0 = 0;
                c1 = 0;
            end
            for (int r = 0; r < 3; r++) begin
                ew[3*r]   = ew[3*r+1];
                ew[3*r+1] = ew[3*r+2];
            end
            ew[2] = c0;
            ew[5] = c1;
            ew[8] = int'(p);
            m_x = (m_x < 4095) ? m_x + 1 : 4095;
        end
        if (fall) begin
`ifdef LINE_WIDTH_CHK_EN
            if (m_y == 0) m_ref = m_x;
            else if (m_x != m_ref) m_err = 1;
`endif
            m_x = 0;
            m_y = (m_y < 2047) ? m_y + 1 : 2047;
        end
        if (rise) begin
            m_y   = 0;
            m_err = 0;
        end
        m_prev_de = de;
        m_prev_vs = vs;
        if (!de) m_line_ok = 1;
    endtask

    task automatic compare();
        logic [9*DW-1:0] ex, mk;
        ex = '0;
        mk = '0;
        for (int i = 0; i < 9; i++)
            if (ew[i] >= 0) begin
                ex[i*DW +: DW] = DW'(ew[i]);
                mk[i*DW +: DW] = '1;
            end
        chk("synco", synco, e_sync);
        chk("win_valid", win_valid, e_valid);
        chk("err_width", err_width, m_err);
        chk("win", win & mk, ex);
    endtask

    // One clock: drive, let the DUT sample, check outputs, advance the model
    task automatic step(input logic r, input logic [2:0] s, input logic [DW-1:0] p);
        rst = r; synci = s; pix_i = p;
        @(posedge clk);
        if (r) model_reset();
        #1;
        compare();
        if (win_valid) begin
            vcnt++;
            if (!got_first) begin
                got_first = 1;
                first_win = win;
            end
        end
        if (!r) model_update(s, p);
    endtask

    // One active line of width w (pixel = 16*row + col) then blanking with hsync
    task automatic line(input int w, input int row, input int blank, input bit vs_at_fall);
        for (int i = 0; i < w; i++) step(1'b0, 3'b001, DW'(16*row + i));
        for (int i = 0; i < blank; i++)
            step(1'b0, {(i == 0) && vs_at_fall, 1'b1, 1'b0}, '0);
    endtask

    task automatic vblank();
        step(1'b0, 3'b100, '0);
        step(1'b0, 3'b100, '0);
        step(1'b0, 3'b000, '0);
    endtask

    initial begin
        for (int i = 0; i < 9; i++) ew[i] = -1;
        rst = 1'b0; synci = '0; pix_i = '0;
        vcnt = 0; got_first = 0; first_win = '0;

        // 1: reset held 3 cycles, then idle; nothing may go valid
        for (int i = 0; i < 3; i++) step(1'b1, 3'b000, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 3'b000, '0);
        chk("reset_idle_valid_cnt", vcnt, 0);
        chk("reset_win", win, '0);

        // 2: 8x4 ramp frame
        vcnt = 0; got_first = 0;
        for (int r = 0; r < 4; r++) line(8, r, 2, 1'b0);
        chk("ramp_valid_cnt", vcnt, 12);
        chk("ramp_got_first", got_first, 1'b1);
        chk("ramp_first_win", first_win, 72'h22_21_20_12_11_10_02_01_00);

        // 3: arbitrary sync pattern, every output checked against the model
        for (int i = 0; i < 300; i++) begin
            logic [2:0] s;
            s[0] = ($urandom_range(0, 3) != 0);
            s[1] = $urandom_range(0, 1) != 0;
            s[2] = ($urandom_range(0, 15) == 0);
            step(1'b0, s, DW'($urandom));
        end
        // random-length lines, including some beyond the buffer depth
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 7) == 0) vblank();
            line($urandom_range(1, 20), $urandom_range(0, 15), $urandom_range(1, 3), 1'b0);
        end

        // 4: vsync rise coincides with de fall; next two lines must not go valid
        vblank();
        for (int r = 0; r < 3; r++) line(8, r, 2, 1'b0);
        line(8, 3, 2, 1'b1);
        vcnt = 0;
        line(8, 4, 2, 1'b0);
        line(8, 5, 2, 1'b0);
        chk("coinc_two_lines_valid", vcnt, 0);
        vcnt = 0;
        line(8, 6, 2, 1'b0);
        chk("coinc_third_line_valid", vcnt, 6);

        // 5: line 2 narrower than line 0
        vblank();
        line(8, 0, 2, 1'b0);
        line(8, 1, 2, 1'b0);
        chk("width_err_before", err_width, 1'b0);
        line(7, 2, 2, 1'b0);
        chk("width_err_set", err_width, EXP_ERR);
        line(8, 3, 2, 1'b0);
        chk("width_err_hold", err_width, EXP_ERR);
        vblank();
        chk("width_err_clr", err_width, 1'b0);

        // lines wider than the buffer depth
        vcnt = 0;
        line(20, 0, 2, 1'b0);
        line(20, 1, 2, 1'b0);
        line(20, 2, 2, 1'b0);
        chk("wide_valid_cnt", vcnt, MAX_W - 2);

        // 6: reset pulsed mid-line 3, partial line continues, then 4 lines
        vblank();
        for (int r = 0; r < 3; r++) line(8, r, 2, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 3'b001, DW'(48 + i));
        step(1'b1, 3'b001, DW'(52));
        for (int i = 5; i < 8; i++) step(1'b0, 3'b001, DW'(48 + i));
        step(1'b0, 3'b010, '0);
        step(1'b0, 3'b010, '0);
        vcnt = 0;
        line(8, 8, 2, 1'b0);
        chk("rst_line1_valid", vcnt, 0);
        vcnt = 0;
        line(8, 9, 2, 1'b0);
        chk("rst_line2_valid", vcnt, 0);
        vcnt = 0;
        line(8, 10, 2, 1'b0);
        chk("rst_line3_valid", vcnt, 6);
        line(8, 11, 2, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 3'b000, '0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
